reg_fifo: RTL and testbench

Parametrised first-in/first-out buffer built from enable-gated registers and a read-select multiplexer. It is the successor to the team's single enabled register and 2:1 mux: `DEPTH` storage words of `WIDTH` bits each, with push/pop enables, full/empty/occupancy status and sticky error reporting. It sits between a data producer and a slower consumer in the lab datapath, for example buffering inputs ahead of the sorter or ALU.

---
 rtl/reg_fifo_if.sv | 28 ++
 rtl/reg_fifo.sv | 76 +++++++
 tb/tb_reg_fifo.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/reg_fifo_if.sv
// Handshake bundle between a data producer/consumer and reg_fifo.
// The slave modport is the FIFO side; the master modport is the user side.
interface reg_fifo_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             push;
  logic [WIDTH-1:0] din;
  logic             pop;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             empty;
  logic [AW:0]      count;
  logic             ovf;
  logic             udf;

  modport slave (
    input  push, din, pop,
    output dout, full, empty, count, ovf, udf
  );

  modport master (
    output push, din, pop,
    input  dout, full, empty, count, ovf, udf
  );
endinterface

// File: rtl/reg_fifo.sv
// Register-array FIFO with registered read data, occupancy status and
// sticky overflow/underflow flags.
module reg_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input logic       clk,
  input logic       rst,
  reg_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW:0]      count;
  logic [WIDTH-1:0] dout;
  logic             ovf;
  logic             udf;
  logic             full;
  logic             empty;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // A pop while full frees the head slot, so a simultaneous push is accepted too.
  assign pop_ok  = bus.pop & ~empty;
  assign push_ok = bus.push & (~full | pop_ok);

  // Storage carries no reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wp] <= bus.din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      dout  <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      if (push_ok) begin
        wp <= wp + 1'b1;
      end
      if (pop_ok) begin
        rp   <= rp + 1'b1;
        dout <= mem[rp];
      end
      if (push_ok && !pop_ok) begin
        count <= count + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count <= count - 1'b1;
      end
      if (bus.push && !push_ok) begin
        ovf <= 1'b1;
      end
      if (bus.pop && empty) begin
        udf <= 1'b1;
      end
    end
  end

  assign bus.dout  = dout;
  assign bus.full  = full;
  assign bus.empty = empty;
  assign bus.count = count;
  assign bus.ovf   = ovf;
  assign bus.udf   = udf;
endmodule

// File: tb/tb_reg_fifo.sv
// Directed self-checking bench for reg_fifo (WIDTH=4, DEPTH=8).
module tb_reg_fifo;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  reg_fifo_if #(.WIDTH(4), .DEPTH(8)) bus ();

  reg_fifo #(.WIDTH(4), .DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of requests, then return 1 ns after the edge to sample.
  task automatic applyStimulus(input logic p, input logic [3:0] d, input logic q);
    bus.push = p;
    bus.din  = d;
    bus.pop  = q;
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  // Reset is raised between edges and the outputs are checked before any edge.
  task automatic test_reset(input string tag);
    rst = 1'b1;
    #2;
    n_checks++;
    if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.count !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL %s status: empty=%b full=%b count=%0d, want 1 0 0", tag, bus.empty, bus.full, bus.count);
    end
    n_checks++;
    if (bus.dout !== 4'd0 || bus.ovf !== 1'b0 || bus.udf !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL %s data/flags: dout=%0d ovf=%b udf=%b, want 0 0 0", tag, bus.dout, bus.ovf, bus.udf);
    end
    rst = 1'b0;
  endtask

  task automatic test_fill_overflow();
    test_reset("reset_fill");
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 4'(i), 1'b0);
    end
    n_checks++;
    if (bus.full !== 1'b1 || bus.count !== 4'd8) begin
      n_fail++;
      $display("[TB] FAIL fill: full=%b count=%0d, want 1 8", bus.full, bus.count);
    end
    applyStimulus(1'b1, 4'd9, 1'b0);
    n_checks++;
    if (bus.ovf !== 1'b1 || bus.count !== 4'd8) begin
      n_fail++;
      $display("[TB] FAIL overflow: ovf=%b count=%0d, want 1 8", bus.ovf, bus.count);
    end
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b0, 4'd0, 1'b1);
      n_checks++;
      if (bus.dout !== 4'(i)) begin
        n_fail++;
        $display("[TB] FAIL drain[%0d]: dout=%0d, want %0d", i, bus.dout, i);
      end
    end
    n_checks++;
    if (bus.empty !== 1'b1 || bus.udf !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL drained: empty=%b udf=%b, want 1 0", bus.empty, bus.udf);
    end
  endtask

  task automatic test_empty_pop();
    test_reset("reset_empty");
    applyStimulus(1'b0, 4'd0, 1'b1);
    n_checks++;
    if (bus.dout !== 4'd0 || bus.udf !== 1'b1 || bus.count !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL underflow: dout=%0d udf=%b count=%0d, want 0 1 0", bus.dout, bus.udf, bus.count);
    end
    applyStimulus(1'b1, 4'd5, 1'b1);
    n_checks++;
    if (bus.count !== 4'd1 || bus.dout !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL push_pop_empty: count=%0d dout=%0d, want 1 0", bus.count, bus.dout);
    end
    applyStimulus(1'b0, 4'd0, 1'b1);
    n_checks++;
    if (bus.dout !== 4'd5 || bus.empty !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL pop_after_empty: dout=%0d empty=%b, want 5 1", bus.dout, bus.empty);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] q[$];
    logic [3:0] d;
    logic [3:0] exp;
    test_reset("reset_wrap");
    d = 4'd1;
    for (int rep = 0; rep < 4; rep++) begin
      for (int k = 0; k < 3; k++) begin
        applyStimulus(1'b1, d, 1'b0);
        q.push_back(d);
        d = d + 4'd1;
        n_checks++;
        if (bus.count !== 4'(k + 1)) begin
          n_fail++;
          $display("[TB] FAIL wrap_count_push: count=%0d, want %0d", bus.count, k + 1);
        end
      end
      for (int k = 0; k < 3; k++) begin
        applyStimulus(1'b0, 4'd0, 1'b1);
        exp = q.pop_front();
        n_checks++;
        if (bus.dout !== exp || bus.count !== 4'(2 - k)) begin
          n_fail++;
          $display("[TB] FAIL wrap_pop: dout=%0d count=%0d, want %0d %0d", bus.dout, bus.count, exp, 2 - k);
        end
      end
    end
  endtask

  task automatic test_full_both();
    test_reset("reset_full_both");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 4'(i), 1'b0);
    end
    applyStimulus(1'b1, 4'd8, 1'b1);
    n_checks++;
    if (bus.dout !== 4'd0 || bus.count !== 4'd8 || bus.full !== 1'b1 || bus.ovf !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL full_both: dout=%0d count=%0d full=%b ovf=%b, want 0 8 1 0", bus.dout, bus.count, bus.full, bus.ovf);
    end
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b0, 4'd0, 1'b1);
      n_checks++;
      if (bus.dout !== 4'(i)) begin
        n_fail++;
        $display("[TB] FAIL full_both_drain[%0d]: dout=%0d, want %0d", i, bus.dout, i);
      end
    end
  endtask

  task automatic test_reset_mid();
    test_reset("reset_pre_mid");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 4'(10 + i), 1'b0);
    end
    applyStimulus(1'b1, 4'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4'd0, 1'b1);
    end
    n_checks++;
    if (bus.count !== 4'd5 || bus.ovf !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL mid_setup: count=%0d ovf=%b, want 5 1", bus.count, bus.ovf);
    end
    test_reset("reset_mid");
    applyStimulus(1'b1, 4'd6, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b1);
    n_checks++;
    if (bus.dout !== 4'd6 || bus.empty !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL after_mid_reset: dout=%0d empty=%b, want 6 1", bus.dout, bus.empty);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    bus.din  = 4'd0;
    #2;
    test_reset("reset_initial");
    applyStimulus(1'b0, 4'd0, 1'b0);
    n_checks++;
    if (bus.empty !== 1'b1 || bus.count !== 4'd0 || bus.dout !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL idle: empty=%b count=%0d dout=%0d, want 1 0 0", bus.empty, bus.count, bus.dout);
    end
    test_fill_overflow();
    test_empty_pop();
    test_wrap();
    test_full_both();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
